dmem_wait_resp: RTL and testbench

DMEM_WAIT_RESP -- requirements
Module: dmem_wait_resp

---
 rtl/dmem_wait_resp.sv | 142 ++++++++++++++
 tb/tb_dmem_wait_resp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_resp.sv
// dmem_wait_resp: word-addressed 32-bit data memory with a fixed number of
// wait states per access, a one-cycle ready strobe and a registered rdata.
// Optional alignment/range checking is built when DMEM_BOUNDS_CHK_EN is defined;
// otherwise err is held at 0 and out-of-range addresses alias onto the array.
module dmem_wait_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              armed;
  logic              op_wr;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              bad_q;
  logic [31:0]       mem [DEPTH];

  logic              accept_c;
  logic              bad_in_c;
  logic              enter_c;
  logic              e_wr_c;
  logic              e_bad_c;
  logic [ADDR_W-1:0] e_idx_c;
  logic [31:0]       e_data_c;

`ifdef DMEM_BOUNDS_CHK_EN
  // Flag misaligned addresses and any address bit beyond the array span.
  assign bad_in_c = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
`else
  // Without checking, byte offset and high bits simply alias.
  assign bad_in_c = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

  // Acceptance and selection of the access that completes on this edge:
  // live inputs for a zero-wait access, latched values otherwise.
  always_comb begin
    accept_c = armed && (state == S_IDLE) && cs && (rd || wr);
    enter_c  = 1'b0;
    e_wr_c   = op_wr;
    e_bad_c  = bad_q;
    e_idx_c  = idx_q;
    e_data_c = wdata_q;
    if ((state == S_WAIT) && (cnt == '0)) begin
      enter_c = 1'b1;
    end
    if (accept_c && (WAIT_CYC == 0)) begin
      enter_c  = 1'b1;
      e_wr_c   = wr;
      e_bad_c  = bad_in_c;
      e_idx_c  = addr[ADDR_W+1:2];
      e_data_c = wdata;
    end
  end

  // Blocks acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Access FSM with latched request, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      op_wr   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            op_wr   <= wr;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            bad_q   <= bad_in_c;
            if (WAIT_CYC == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter_c) begin
        ready <= 1'b1;
        err   <= e_bad_c;
        if (!e_wr_c) begin
          rdata <= e_bad_c ? BAD_DATA : mem[e_idx_c];
        end
      end
    end
  end

  // Array write on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_c && e_wr_c && !e_bad_c) begin
      mem[e_idx_c] <= e_data_c;
    end
  end

endmodule

// File: tb/tb_dmem_wait_resp.sv
// tb_dmem_wait_resp: two instances (2 wait states and 0 wait states) checked
// every cycle against a transaction-level model, plus literal expectations.
// Expectations follow DMEM_BOUNDS_CHK_EN when it is defined.
module tb_dmem_wait_resp;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] SPAN   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_i    [2];
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        err_o   [2];

  int checks;
  int errors;

  // model state
  int          cyc;
  bit          m_busy  [2];
  int          m_done  [2];
  logic        m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_rdata [2];
  logic        m_ready [2];
  logic        m_err   [2];
  logic [31:0] mmem    [2][1024];

  dmem_wait_resp #(.ADDR_W(ADDR_W), .WAIT_CYC(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .cs(cs_i[0]), .rd(rd_i[0]), .wr(wr_i[0]),
    .addr(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata_o[0]),
    .ready(ready_o[0]), .err(err_o[0])
  );

  dmem_wait_resp #(.ADDR_W(ADDR_W), .WAIT_CYC(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .cs(cs_i[1]), .rd(rd_i[1]), .wr(wr_i[1]),
    .addr(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata_o[1]),
    .ready(ready_o[1]), .err(err_o[1])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHK_EN
    return ((a % 4) != 0) || (a >= SPAN);
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a % SPAN) / 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_busy[k]  = 1'b0;
      m_ready[k] = 1'b0;
      m_err[k]   = 1'b0;
      m_rdata[k] = 32'h0;
    end
  endtask

  // Transaction model: an access accepted on edge n completes on edge n+W
  // and the instance accepts nothing until edge n+W+2.
  task automatic model_edge();
    if (!rst) begin
      model_clear();
      return;
    end
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = 1'b0;
      m_err[k]   = 1'b0;
      if (!m_busy[k] && cs_i[k] && (rd_i[k] || wr_i[k])) begin
        m_busy[k] = 1'b1;
        m_done[k] = cyc + lat_of(k);
        m_wr[k]   = wr_i[k];
        m_addr[k] = addr_i[k];
        m_data[k] = wdata_i[k];
      end
      if (m_busy[k] && cyc == m_done[k]) begin
        m_ready[k] = 1'b1;
        m_err[k]   = addr_bad(m_addr[k]);
        if (m_wr[k]) begin
          if (!addr_bad(m_addr[k])) mmem[k][widx(m_addr[k])] = m_data[k];
        end else begin
          m_rdata[k] = addr_bad(m_addr[k]) ? 32'hDEAD_BEEF : mmem[k][widx(m_addr[k])];
        end
      end else if (m_busy[k] && cyc == m_done[k] + 1) begin
        m_busy[k] = 1'b0;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ready[%0d]", k), 32'(ready_o[k]), 32'(m_ready[k]));
      check($sformatf("err[%0d]", k), 32'(err_o[k]), 32'(m_err[k]));
      check($sformatf("rdata[%0d]", k), rdata_o[k], m_rdata[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // One access; optionally scrambles the inputs while it is in flight.
  task automatic req(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit scr,
                     output logic [31:0] rdv, output logic errv, output int lat);
    cs_i[k] = 1'b1; rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; wdata_i[k] = d;
    step();
    lat = 1;
    if (!scr) begin
      cs_i[k] = 1'b0; rd_i[k] = 1'b0; wr_i[k] = 1'b0;
    end
    while (ready_o[k] !== 1'b1 && lat < 20) begin
      if (scr) begin
        cs_i[k]    = 1'($urandom_range(0, 1));
        rd_i[k]    = 1'($urandom_range(0, 1));
        wr_i[k]    = 1'($urandom_range(0, 1));
        addr_i[k]  = $urandom;
        wdata_i[k] = $urandom;
      end
      step();
      lat++;
    end
    cs_i[k] = 1'b0; rd_i[k] = 1'b0; wr_i[k] = 1'b0;
    rdv  = rdata_o[k];
    errv = err_o[k];
    if (ready_o[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout[%0d]: no ready within %0d cycles", k, lat);
    end
    step();
  endtask

  logic [31:0] rv;
  logic        ev;
  int          lat;
  int          nrdy;
  bit          bnd;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    bnd    = addr_bad(32'h6);
    for (int k = 0; k < 2; k++) begin
      cs_i[k] = 1'b0; rd_i[k] = 1'b0; wr_i[k] = 1'b0;
      addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
      for (int i = 0; i < 1024; i++) mmem[k][i] = 32'h0;
    end
    model_clear();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) step();
    check("reset_rdata", rdata_o[0], 32'h0);
    check("reset_ready", 32'(ready_o[0]), 32'h0);
    rst = 1'b1;
    repeat (2) step();

    // write then read with two wait states
    req(0, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0, rv, ev, lat);
    check("w2_write_lat", 32'(lat), 32'd3);
    check("w2_write_err", 32'(ev), 32'h0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rv, ev, lat);
    check("w2_read_lat", 32'(lat), 32'd3);
    check("w2_read_data", rv, 32'hA5A5_0001);

    // rd and wr together: write only, rdata untouched
    req(0, 1'b1, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b0, rv, ev, lat);
    check("rdwr_rdata_kept", rv, 32'hA5A5_0001);
    req(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, rv, ev, lat);
    check("rdwr_readback", rv, 32'hCAFE_F00D);

    // inputs scrambled during the wait states
    req(0, 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b1, rv, ev, lat);
    check("scr_write_lat", 32'(lat), 32'd3);
    req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, rv, ev, lat);
    check("scr_read_data", rv, 32'h0BAD_F00D);

    // aliasing or bounds errors depending on build
    req(0, 1'b0, 1'b1, 32'h0, 32'h0000_0077, 1'b0, rv, ev, lat);
    req(0, 1'b0, 1'b1, 32'h4, 32'h0000_0044, 1'b0, rv, ev, lat);
    req(0, 1'b0, 1'b1, 32'h1000, 32'h5555_AAAA, 1'b0, rv, ev, lat);
    check("hi_write_err", 32'(ev), bnd ? 32'h1 : 32'h0);
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rv, ev, lat);
    check("word0", rv, bnd ? 32'h0000_0077 : 32'h5555_AAAA);
    req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, rv, ev, lat);
    check("hi_read", rv, bnd ? 32'hDEAD_BEEF : 32'h5555_AAAA);
    check("hi_read_err", 32'(ev), bnd ? 32'h1 : 32'h0);
    req(0, 1'b1, 1'b0, 32'h6, 32'h0, 1'b0, rv, ev, lat);
    check("misalign_read", rv, bnd ? 32'hDEAD_BEEF : 32'h0000_0044);
    check("misalign_err", 32'(ev), bnd ? 32'h1 : 32'h0);
    check("misalign_lat", 32'(lat), 32'd3);

    // reset during the wait of a write drops it
    req(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, rv, ev, lat);
    cs_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 32'h20; wdata_i[0] = 32'h1111_2222;
    step();
    cs_i[0] = 1'b0; wr_i[0] = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
    #1;
    check("async_rst_rdata", rdata_o[0], 32'h0);
    check("async_rst_ready", 32'(ready_o[0]), 32'h0);
    compare();
    nrdy = 0;
    repeat (4) begin
      step();
      if (ready_o[0] === 1'b1) nrdy++;
    end
    rst = 1'b1;
    repeat (2) begin
      step();
      if (ready_o[0] === 1'b1) nrdy++;
    end
    check("rst_no_ready", 32'(nrdy), 32'h0);
    check("rst_rdata1", rdata_o[1], 32'h0);
    req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rv, ev, lat);
    check("rst_dropped_write", rv, 32'h0);
    check("rst_read_lat", 32'(lat), 32'd3);

    // zero wait states
    req(1, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, rv, ev, lat);
    check("w0_write_lat", 32'(lat), 32'd1);
    req(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rv, ev, lat);
    check("w0_read_lat", 32'(lat), 32'd1);
    check("w0_read_data", rv, 32'h1234_5678);

    // held request re-accepted every two cycles
    cs_i[1] = 1'b1; rd_i[1] = 1'b1; addr_i[1] = 32'h0;
    nrdy = 0;
    repeat (8) begin
      step();
      if (ready_o[1] === 1'b1) nrdy++;
    end
    cs_i[1] = 1'b0; rd_i[1] = 1'b0;
    check("w0_held_readies", 32'(nrdy), 32'd4);
    repeat (2) step();
    check("w0_held_rdata", rdata_o[1], 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
